// File: rtl/core_pkg.sv
// Shared pipeline-control types: forwarding select encoding and the per-stage register tag record.
package core_pkg;

  // Tags hold register indices zero-extended to TAG_AW, so one struct serves any index width up to 8.
  localparam int TAG_AW = 8;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic              valid;
    logic [TAG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
    logic [TAG_AW-1:0] rs1;
    logic [TAG_AW-1:0] rs2;
  } stage_tag_t;

  // x0 is hardwired to zero, so it never produces a hazard or a forward.
  function automatic logic tag_hit(input stage_tag_t t, input logic [TAG_AW-1:0] r);
    return t.valid && t.reg_write && (t.rd == r) && (r != '0);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Performance counter that increments on inc_i and sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 inc_i,
  output logic [CNT_WIDTH-1:0] count_o
);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i)      count_o <= '0;
    else if (inc_i) count_o <= sat_inc(count_o);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding control for the 5-stage core: tracks EX/MEM/WB register tags and
// drives PC / IF-ID enables, flush, ID-EX bubble, ALU operand selects and perf counters.
module pipe_hazard_ctrl
  import core_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 32,
  parameter int FWD_EN     = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  id_valid_i,
  input  logic [ADDR_WIDTH-1:0] id_rs1_i,
  input  logic [ADDR_WIDTH-1:0] id_rs2_i,
  input  logic                  id_uses_rs1_i,
  input  logic                  id_uses_rs2_i,
  input  logic [ADDR_WIDTH-1:0] id_rd_i,
  input  logic                  id_reg_write_i,
  input  logic                  id_mem_read_i,
  input  logic                  ex_redirect_i,
  input  logic                  mem_ready_i,
  output logic                  pc_en_o,
  output logic                  if_id_en_o,
  output logic                  if_id_flush_o,
  output logic                  id_ex_bubble_o,
  output logic                  ex_valid_o,
  output logic                  mem_valid_o,
  output logic                  wb_valid_o,
  output logic [1:0]            fwd_a_o,
  output logic [1:0]            fwd_b_o,
  output logic [CNT_WIDTH-1:0]  retired_o,
  output logic [CNT_WIDTH-1:0]  stall_cnt_o,
  output logic [CNT_WIDTH-1:0]  flush_cnt_o
);

  stage_tag_t id_tag;
  stage_tag_t ex_p0, mem_p1, wb_p2;
  logic       adv;
  logic       ex_use, mem_use, wb_use;
  logic       load_use, raw, hz;
  fwd_sel_t   fwd_a, fwd_b;
  logic       unused_wb_fields;

  // MEM wins over WB because it holds the younger write; a load in MEM has no data yet.
  function automatic fwd_sel_t fwd_sel(input stage_tag_t m, input stage_tag_t w,
                                       input logic [TAG_AW-1:0] r);
    if (tag_hit(m, r) && !m.mem_read) return FWD_MEM;
    if (tag_hit(w, r))                return FWD_WB;
    return FWD_RF;
  endfunction

  function automatic logic src_hit(input stage_tag_t t, input stage_tag_t id,
                                   input logic u1, input logic u2);
    return (u1 && tag_hit(t, id.rs1)) || (u2 && tag_hit(t, id.rs2));
  endfunction

  assign adv = mem_ready_i;

  always_comb begin
    id_tag           = '0;
    id_tag.valid     = id_valid_i;
    id_tag.rd        = TAG_AW'(id_rd_i);
    id_tag.reg_write = id_reg_write_i;
    id_tag.mem_read  = id_mem_read_i;
    id_tag.rs1       = TAG_AW'(id_rs1_i);
    id_tag.rs2       = TAG_AW'(id_rs2_i);
  end

  assign ex_use   = src_hit(ex_p0,  id_tag, id_uses_rs1_i, id_uses_rs2_i);
  assign mem_use  = src_hit(mem_p1, id_tag, id_uses_rs1_i, id_uses_rs2_i);
  assign wb_use   = src_hit(wb_p2,  id_tag, id_uses_rs1_i, id_uses_rs2_i);
  assign load_use = id_valid_i && ex_use && ex_p0.mem_read;
  assign raw      = id_valid_i && (ex_use || mem_use || wb_use);
  assign hz       = (FWD_EN != 0) ? load_use : raw;

  always_comb begin
    pc_en_o        = 1'b0;
    if_id_en_o     = 1'b0;
    if_id_flush_o  = 1'b0;
    id_ex_bubble_o = 1'b0;
    if (rst_i) begin
      if_id_flush_o  = 1'b1;
      id_ex_bubble_o = 1'b1;
    end else if (!adv) begin
      pc_en_o = 1'b0;
    end else if (ex_redirect_i) begin
      pc_en_o        = 1'b1;
      if_id_en_o     = 1'b1;
      if_id_flush_o  = 1'b1;
      id_ex_bubble_o = 1'b1;
    end else if (hz) begin
      id_ex_bubble_o = 1'b1;
    end else begin
      pc_en_o    = 1'b1;
      if_id_en_o = 1'b1;
    end
  end

  // ID -> EX (p0) -> MEM (p1) -> WB (p2); only the valid bits are reset.
  always_ff @(posedge clk_i) begin
    if (adv) begin
      ex_p0       <= id_tag;
      ex_p0.valid <= id_valid_i && !hz && !ex_redirect_i;
      mem_p1      <= ex_p0;
      wb_p2       <= mem_p1;
    end
    if (rst_i) begin
      ex_p0.valid  <= 1'b0;
      mem_p1.valid <= 1'b0;
      wb_p2.valid  <= 1'b0;
    end
  end

  assign unused_wb_fields = ^{wb_p2.mem_read, wb_p2.rs1, wb_p2.rs2};

  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (!rst_i && (FWD_EN != 0) && ex_p0.valid) begin
      fwd_a = fwd_sel(mem_p1, wb_p2, ex_p0.rs1);
      fwd_b = fwd_sel(mem_p1, wb_p2, ex_p0.rs2);
    end
  end

  assign fwd_a_o     = fwd_a;
  assign fwd_b_o     = fwd_b;
  assign ex_valid_o  = ex_p0.valid;
  assign mem_valid_o = mem_p1.valid;
  assign wb_valid_o  = wb_p2.valid;

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_retired (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (adv && wb_p2.valid),
    .count_o (retired_o)
  );

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   ((!adv || hz) && !ex_redirect_i),
    .count_o (stall_cnt_o)
  );

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_flush (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (adv && ex_redirect_i),
    .count_o (flush_cnt_o)
  );

endmodule
